cacheline_mem_arbiter: RTL

//   Shares the single physical-memory line port between I-cache fills and D-cache fills/writebacks.

---
 rtl/cacheline_mem_arbiter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/cacheline_mem_arbiter.sv
// Arbitrates I-cache and D-cache line transactions onto one memory port; sticky watchdog on a stuck memory.
// Latency: command registered 1 cycle after request; response forwarded combinationally; 1 RECOVER bubble.
// Backpressure: requests are levels held until their resp; ARB_RR_EN selects round-robin over fixed D priority.
module cacheline_mem_arbiter #(
    parameter int LINE_W      = 256,
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read_i,
    input  logic [ADDR_W-1:0] i_addr_i,
    output logic [LINE_W-1:0] i_rdata_o,
    output logic              i_resp_o,
    input  logic              d_read_i,
    input  logic              d_write_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [LINE_W-1:0] d_wdata_i,
    output logic [LINE_W-1:0] d_rdata_o,
    output logic              d_resp_o,
    output logic              pm_read_o,
    output logic              pm_write_o,
    output logic [ADDR_W-1:0] pm_addr_o,
    output logic [LINE_W-1:0] pm_wdata_o,
    input  logic [LINE_W-1:0] pm_rdata_i,
    input  logic              pm_resp_i,
    output logic              timeout_err_o
);
    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam bit WD_EN = (TIMEOUT_CYC != 0);

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RECOVER} state_t;

    state_t            state_q;
    logic              pm_read_q;
    logic              pm_write_q;
    logic [ADDR_W-1:0] pm_addr_q;
    logic [LINE_W-1:0] pm_wdata_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              err_q;
    logic              err_d;
    logic              d_req;
    logic              grant_d;
    logic              grant_i;
    logic              serving;

    assign d_req   = d_read_i | d_write_i;
    assign serving = (state_q == SERVE_I) || (state_q == SERVE_D);

`ifdef ARB_RR_EN
    logic last_d_q;

    // On a tie, D wins only if I was the previous grant.
    assign grant_d = d_req & (~i_read_i | ~last_d_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            last_d_q <= 1'b1;
        end else if (state_q == IDLE && (grant_d || grant_i)) begin
            last_d_q <= grant_d;
        end
    end
`else
    assign grant_d = d_req;
`endif

    assign grant_i = i_read_i & ~grant_d;

    always_comb begin
        cnt_d = (cnt_q == LIMIT) ? cnt_q : cnt_q + CNT_W'(1);
        err_d = err_q;
        if (WD_EN && serving && !pm_resp_i && cnt_d == LIMIT) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pm_read_q  <= 1'b0;
            pm_write_q <= 1'b0;
            pm_addr_q  <= '0;
            pm_wdata_q <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            err_q <= err_d;
            case (state_q)
                IDLE: begin
                    if (grant_d || grant_i) begin
                        // A simultaneous read+write from D is served as a write.
                        pm_addr_q  <= grant_d ? d_addr_i : i_addr_i;
                        pm_read_q  <= grant_i | (grant_d & ~d_write_i);
                        pm_write_q <= grant_d & d_write_i;
                        if (grant_d && d_write_i) begin
                            pm_wdata_q <= d_wdata_i;
                        end
                        cnt_q   <= '0;
                        state_q <= grant_d ? SERVE_D : SERVE_I;
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (pm_resp_i) begin
                        pm_read_q  <= 1'b0;
                        pm_write_q <= 1'b0;
                        state_q    <= RECOVER;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                RECOVER: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pm_read_o     = pm_read_q;
    assign pm_write_o    = pm_write_q;
    assign pm_addr_o     = pm_addr_q;
    assign pm_wdata_o    = pm_wdata_q;
    assign timeout_err_o = err_q;
    assign i_rdata_o     = pm_rdata_i;
    assign d_rdata_o     = pm_rdata_i;
    assign i_resp_o      = (state_q == SERVE_I) & pm_resp_i;
    assign d_resp_o      = (state_q == SERVE_D) & pm_resp_i;
endmodule
